// File: rtl/cla_pkg.sv
// Shared constants for the CLA adder arbiter: requester ids, adder latency and
// the in-flight tag carried alongside each adder issue.
package cla_pkg;

  localparam int   LATENCY  = 2;
  localparam logic REQ_ID_0 = 1'b0;
  localparam logic REQ_ID_1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/N_bit_cla_adder_pipeline_optimized.sv
// Two-stage carry-select adder built from two half-width lookahead blocks.
// Stage 1 adds the low half and both carry variants of the high half; stage 2 selects.
module N_bit_cla_adder_pipeline_optimized #(
  parameter int DATA_WID = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DATA_WID-1:0] a,
  input  logic [DATA_WID-1:0] b,
  input  logic                cin,
  output logic [DATA_WID-1:0] sum,
  output logic                cout
);

  localparam int H = DATA_WID / 2;

  // Generate/propagate carry lookahead over one half; returns {carry_out, sum}.
  function automatic logic [H:0] cla_half(input logic [H-1:0] x,
                                          input logic [H-1:0] y,
                                          input logic         c0);
    logic [H-1:0] g;
    logic [H-1:0] p;
    logic [H:0]   c;
    g    = x & y;
    p    = x ^ y;
    c[0] = c0;
    for (int i = 0; i < H; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[H], p ^ c[H-1:0]};
  endfunction

  logic [H:0] lo_q;
  logic [H:0] hi0_q;
  logic [H:0] hi1_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      lo_q  <= '0;
      hi0_q <= '0;
      hi1_q <= '0;
    end else begin
      lo_q  <= cla_half(a[H-1:0], b[H-1:0], cin);
      hi0_q <= cla_half(a[DATA_WID-1:H], b[DATA_WID-1:H], 1'b0);
      hi1_q <= cla_half(a[DATA_WID-1:H], b[DATA_WID-1:H], 1'b1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (lo_q[H]) begin
      sum  <= {hi1_q[H-1:0], lo_q[H-1:0]};
      cout <= hi1_q[H];
    end else begin
      sum  <= {hi0_q[H-1:0], lo_q[H-1:0]};
      cout <= hi0_q[H];
    end
  end

endmodule

// File: rtl/cla_add_arbiter.sv
// Two-requester round-robin front end sharing one pipelined CLA adder.
// A tag pipeline tracks which requester each in-flight result belongs to.
module cla_add_arbiter #(
  parameter int DATA_WID = 32,
  parameter int LATENCY  = cla_pkg::LATENCY
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATA_WID-1:0] req0_in1,
  input  logic [DATA_WID-1:0] req0_in2,
  input  logic                req0_cin,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATA_WID-1:0] req1_in1,
  input  logic [DATA_WID-1:0] req1_in2,
  input  logic                req1_cin,
  output logic                rsp0_valid,
  output logic [DATA_WID-1:0] rsp0_sum,
  output logic                rsp0_cout,
  output logic                rsp1_valid,
  output logic [DATA_WID-1:0] rsp1_sum,
  output logic                rsp1_cout,
  output logic                busy
);

  import cla_pkg::*;

  logic                ptr;
  logic                grant0;
  logic                grant1;
  logic                accept;
  logic                grant_id;
  logic [DATA_WID-1:0] add_a;
  logic [DATA_WID-1:0] add_b;
  logic                add_cin;
  logic [DATA_WID-1:0] add_sum;
  logic                add_cout;
  logic                tags_busy;
  tag_t                tag_q [LATENCY];
  tag_t                tag_out;

  always_comb begin
    grant0 = req0_valid && (!req1_valid || ptr == REQ_ID_0);
    grant1 = req1_valid && (!req0_valid || ptr == REQ_ID_1);
  end

  assign req0_ready = grant0 && !reset;
  assign req1_ready = grant1 && !reset;
  assign accept     = req0_ready || req1_ready;
  assign grant_id   = req1_ready ? REQ_ID_1 : REQ_ID_0;

  // Pointer moves to the requester that was not just served.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= REQ_ID_0;
    end else if (accept) begin
      ptr <= ~grant_id;
    end
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (req0_ready) begin
      add_a   = req0_in1;
      add_b   = req0_in2;
      add_cin = req0_cin;
    end else if (req1_ready) begin
      add_a   = req1_in1;
      add_b   = req1_in2;
      add_cin = req1_cin;
    end
  end

  N_bit_cla_adder_pipeline_optimized #(
    .DATA_WID (DATA_WID)
  ) u_adder (
    .clock (clock),
    .reset (reset),
    .a     (add_a),
    .b     (add_b),
    .cin   (add_cin),
    .sum   (add_sum),
    .cout  (add_cout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: accept, id: grant_id};
      for (int i = 1; i < LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    tags_busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      tags_busy = tags_busy | tag_q[i].valid;
    end
  end

  assign tag_out = tag_q[LATENCY-1];
  assign busy    = tags_busy || accept;

  // Masking with reset drops a result that would otherwise surface during the reset cycle.
  assign rsp0_valid = tag_out.valid && (tag_out.id == REQ_ID_0) && !reset;
  assign rsp1_valid = tag_out.valid && (tag_out.id == REQ_ID_1) && !reset;
  assign rsp0_sum   = add_sum;
  assign rsp1_sum   = add_sum;
  assign rsp0_cout  = add_cout;
  assign rsp1_cout  = add_cout;

endmodule

// File: tb/tb_cla_add_arbiter.sv
// Randomized bench for cla_add_arbiter against a queue-based reference model
// with directed carry, contention and mid-flight reset sequences.
module tb_cla_add_arbiter;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic         req0_cin, req1_cin;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp0_sum, rsp1_sum;
  logic         rsp0_cout, rsp1_cout;
  logic         busy;

  cla_add_arbiter #(.DATA_WID(W)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_sum(rsp0_sum), .rsp0_cout(rsp0_cout),
    .rsp1_valid(rsp1_valid), .rsp1_sum(rsp1_sum), .rsp1_cout(rsp1_cout),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         due;
    logic       id;
    logic [W:0] res;
  } exp_t;

  exp_t         q[$];
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  logic         ptr = 1'b0;
  int           wait1 = 0;
  logic         pv [2];
  logic [W-1:0] pa [2];
  logic [W-1:0] pb [2];
  logic         pc [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic load(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    pv[id] = 1'b1;
    pa[id] = a;
    pb[id] = b;
    pc[id] = c;
  endtask

  // One clock cycle: drive, check ready/busy/response, then advance the model.
  task automatic step(input logic rst);
    logic g0, g1, id;
    exp_t e;
    @(negedge clock);
    cyc++;
    reset      = rst;
    req0_valid = pv[0]; req0_in1 = pa[0]; req0_in2 = pb[0]; req0_cin = pc[0];
    req1_valid = pv[1]; req1_in1 = pa[1]; req1_in2 = pb[1]; req1_cin = pc[1];
    #1;
    g0 = !rst && pv[0] && (!pv[1] || ptr == 1'b0);
    g1 = !rst && pv[1] && (!pv[0] || ptr == 1'b1);
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    chk("busy", busy, (q.size() != 0) || g0 || g1);
    if (!rst && q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rsp0_valid", rsp0_valid, e.id == 1'b0);
      chk("rsp1_valid", rsp1_valid, e.id == 1'b1);
      chk(e.id ? "rsp1_sum" : "rsp0_sum", e.id ? rsp1_sum : rsp0_sum, e.res[W-1:0]);
      chk(e.id ? "rsp1_cout" : "rsp0_cout", e.id ? rsp1_cout : rsp0_cout, e.res[W]);
    end else begin
      chk("rsp0_idle", rsp0_valid, 1'b0);
      chk("rsp1_idle", rsp1_valid, 1'b0);
    end
    if (rst) begin
      q.delete();
      ptr   = 1'b0;
      wait1 = 0;
    end else if (g0 || g1) begin
      id = g1;
      e.due = cyc + 2;
      e.id  = id;
      e.res = {1'b0, pa[id]} + {1'b0, pb[id]} + {{W{1'b0}}, pc[id]};
      q.push_back(e);
      ptr = ~id;
      pv[id] = 1'b0;
      if (id) begin
        chk("req1_wait_le1", wait1 <= 1, 1);
        wait1 = 0;
      end
    end
    if (!rst && pv[1] && !g1) wait1++;
  endtask

  initial begin
    pv[0] = 0; pv[1] = 0;
    pa[0] = 0; pa[1] = 0; pb[0] = 0; pb[1] = 0; pc[0] = 0; pc[1] = 0;
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_in1 = 0; req0_in2 = 0; req0_cin = 0;
    req1_in1 = 0; req1_in2 = 0; req1_cin = 0;

    step(1'b1);
    step(1'b1);
    step(1'b0);
    chk("reset_rsp0_sum", rsp0_sum, 0);
    chk("reset_rsp1_sum", rsp1_sum, 0);
    chk("reset_rsp0_cout", rsp0_cout, 0);
    chk("reset_rsp1_cout", rsp1_cout, 0);

    // Single request, then both carry boundaries and the low-half carry-select case.
    load(0, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0);
    chk("single_sum", rsp0_sum, 32'h0001_0000);
    load(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0);
    chk("allones_sum", rsp1_sum, 32'hFFFF_FFFF);
    chk("allones_cout", rsp1_cout, 1'b1);
    load(1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    step(1'b0);
    load(0, 32'h0001_FFFF, 32'h0000_FFFF, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0);

    // Contention from reset: grants must alternate 0,1,0,1.
    step(1'b1);
    for (int i = 0; i < 4; i++) begin
      load(0, $urandom, $urandom, 1'($urandom_range(0, 1)));
      load(1, $urandom, $urandom, 1'($urandom_range(0, 1)));
      step(1'b0);
      chk("rr_order", req1_ready, (i % 2) == 1);
      pv[0] = 0; pv[1] = 0;
    end
    for (int i = 0; i < 3; i++) step(1'b0);

    // Reset with two requests in flight.
    load(0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    step(1'b0);
    load(1, 32'h0F0F_0F0F, 32'h0101_0101, 1'b1);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    chk("busy_after_reset", busy, 1'b0);
    step(1'b0);
    load(0, 32'h5, 32'h6, 1'b0);
    load(1, 32'h7, 32'h8, 1'b1);
    step(1'b0);
    chk("post_reset_grant0", req0_ready, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);

    // Random traffic with occasional resets; operands of a held request never change.
    for (int n = 0; n < 1000; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pv[r] && $urandom_range(0, 99) < 70) begin
          case ($urandom_range(0, 3))
            0:       load(r, 32'hFFFF_FFFF, $urandom, 1'($urandom_range(0, 1)));
            1:       load(r, $urandom_range(0, 3) == 0 ? 32'h8000_0000 : $urandom,
                         32'h8000_0000, 1'($urandom_range(0, 1)));
            default: load(r, $urandom, $urandom, 1'($urandom_range(0, 1)));
          endcase
        end
      end
      step($urandom_range(0, 199) == 0);
    end
    pv[0] = 0; pv[1] = 0;
    for (int i = 0; i < 4; i++) step(1'b0);
    chk("drain_empty", q.size(), 0);
    chk("drain_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
